dmem_port_arbiter: RTL

//  Shares the single dmem port (address/data/wren/q) between two requesters:
//  the processor (P) and a DMA/debug loader (D). It sits between the processor
//  and dmem in the top level. A request is granted in the same cycle it wins.

---
 rtl/dmem_arb_pkg.sv | 18 +
 rtl/rr_pick2.sv | 44 ++++
 rtl/dmem_port_arbiter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared encodings for the dmem port arbiter: owner state and requester indices.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        OWNER_IDLE = 2'd0,
        OWNER_P    = 2'd1,
        OWNER_D    = 2'd2
    } owner_e;

    // Requester index into req/win vectors, also the encoding of 'last'.
    localparam logic REQ_P = 1'b0;
    localparam logic REQ_D = 1'b1;

    function automatic logic [1:0] one_hot(input logic idx);
        return (idx == REQ_P) ? 2'b01 : 2'b10;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way winner select: round-robin on ties, current owner
// keeps the port while its burst count is below the cap.
module rr_pick2
    import dmem_arb_pkg::*;
#(
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = $clog2(MAX_BURST + 1)
) (
    input  logic [1:0]       req,
    input  owner_e           owner,
    input  logic             last,
    input  logic [CNT_W-1:0] burst_cnt,
    output logic [1:0]       win
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

    logic owner_valid;
    logic owner_idx;
    logic hold_owner;

    always_comb begin
        owner_valid = (owner == OWNER_P) || (owner == OWNER_D);
        owner_idx   = (owner == OWNER_D) ? REQ_D : REQ_P;
        hold_owner  = owner_valid && (burst_cnt < MAX_CNT);
    end

    always_comb begin
        win = 2'b00;
        case (req)
            2'b01:   win = 2'b01;
            2'b10:   win = 2'b10;
            2'b11: begin
                if (hold_owner) begin
                    win = one_hot(owner_idx);
                end else begin
                    win = one_hot(~last);
                end
            end
            default: win = 2'b00;
        endcase
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares one dmem port between the processor (P) and a DMA/debug loader (D);
// read data returns one cycle after the grant, tagged per requester.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic                           clock,
    input  logic                           reset,
    // Handshake: a requester holds req (with stable wren/addr/data) until it
    // sees gnt; gnt is combinational and the access happens in that same cycle.
    input  logic                           p_req,
    input  logic                           p_wren,
    input  logic [ADDR_W-1:0]              p_addr,
    input  logic [DATA_W-1:0]              p_data,
    output logic                           p_gnt,
    output logic                           p_rvalid,
    input  logic                           d_req,
    input  logic                           d_wren,
    input  logic [ADDR_W-1:0]              d_addr,
    input  logic [DATA_W-1:0]              d_data,
    output logic                           d_gnt,
    output logic                           d_rvalid,
    output logic [DATA_W-1:0]              rdata,
    output logic [ADDR_W-1:0]              mem_address,
    output logic [DATA_W-1:0]              mem_data,
    output logic                           mem_wren,
    input  logic [DATA_W-1:0]              mem_q,
    output owner_e                         dbg_owner,
    output logic                           dbg_last,
    output logic [$clog2(MAX_BURST+1)-1:0] dbg_burst_cnt
);

    localparam int               CNT_W   = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

    owner_e           owner_q, owner_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
    logic             rd_pend_p_q, rd_pend_p_d;
    logic             rd_pend_d_q, rd_pend_d_d;

    logic [1:0]       req;
    logic [1:0]       win_raw;
    logic [1:0]       win;
    logic [CNT_W-1:0] cnt_inc;

    assign req[REQ_P] = p_req;
    assign req[REQ_D] = d_req;

    rr_pick2 #(
        .MAX_BURST (MAX_BURST),
        .CNT_W     (CNT_W)
    ) u_pick (
        .req       (req),
        .owner     (owner_q),
        .last      (last_q),
        .burst_cnt (burst_cnt_q),
        .win       (win_raw)
    );

    // Nothing is granted while reset is held, so no write can slip through.
    assign win     = reset ? 2'b00 : win_raw;
    assign cnt_inc = (burst_cnt_q >= MAX_CNT) ? MAX_CNT : burst_cnt_q + ONE_CNT;

    always_ff @(posedge clock) begin
        if (reset) begin
            owner_q     <= OWNER_IDLE;
            last_q      <= REQ_D;
            burst_cnt_q <= '0;
            rd_pend_p_q <= 1'b0;
            rd_pend_d_q <= 1'b0;
        end else begin
            owner_q     <= owner_d;
            last_q      <= last_d;
            burst_cnt_q <= burst_cnt_d;
            rd_pend_p_q <= rd_pend_p_d;
            rd_pend_d_q <= rd_pend_d_d;
        end
    end

    always_comb begin
        owner_d     = OWNER_IDLE;
        last_d      = last_q;
        burst_cnt_d = '0;
        rd_pend_p_d = 1'b0;
        rd_pend_d_d = 1'b0;
        if (win[REQ_P]) begin
            owner_d     = OWNER_P;
            last_d      = REQ_P;
            burst_cnt_d = (owner_q == OWNER_P) ? cnt_inc : ONE_CNT;
            rd_pend_p_d = ~p_wren;
        end else if (win[REQ_D]) begin
            owner_d     = OWNER_D;
            last_d      = REQ_D;
            burst_cnt_d = (owner_q == OWNER_D) ? cnt_inc : ONE_CNT;
            rd_pend_d_d = ~d_wren;
        end
    end

    always_comb begin
        p_gnt       = win[REQ_P];
        d_gnt       = win[REQ_D];
        mem_address = '0;
        mem_data    = '0;
        mem_wren    = 1'b0;
        if (win[REQ_P]) begin
            mem_address = p_addr;
            mem_data    = p_data;
            mem_wren    = p_wren;
        end else if (win[REQ_D]) begin
            mem_address = d_addr;
            mem_data    = d_data;
            mem_wren    = d_wren;
        end
    end

    // A read in flight when reset arrives is dropped rather than delivered.
    assign p_rvalid = rd_pend_p_q & ~reset;
    assign d_rvalid = rd_pend_d_q & ~reset;
    assign rdata    = mem_q;

    assign dbg_owner     = owner_q;
    assign dbg_last      = last_q;
    assign dbg_burst_cnt = burst_cnt_q;

endmodule
